keypad_scan: RTL and testbench

- Scans a 4x4 matrix keypad and produces debounced key codes for the menu/text FSM.
- Drives the `key` input of the menu renderer, so menu state transitions come from physical keypad presses.
- Sits between the board keypad pins and the game/menu logic, in the `clk` domain.
- Row inputs are asynchronous and are synchronised internally.

---
 rtl/keypad_scan.sv | 261 ++++++++++++++++++++++++++
 tb/tb_keypad_scan.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with per-sweep debounce and rollover; optional auto-repeat under KEYPAD_REPEAT_EN.
// Latency: outputs are registered on the edge that takes the column-3 sample completing a qualifying sweep.
// Backpressure: none; the scan is free-running and key_press is a single-cycle pulse that is not held.
module keypad_scan #(
    parameter int SCAN_DIV           = 1000,
    parameter int DEBOUNCE_SCANS     = 4,
    parameter int REPEAT_DELAY_SCANS = 32,
    parameter int REPEAT_RATE_SCANS  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_press
);

    localparam int SLOT_W = $clog2(SCAN_DIV);
    localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRESS = 2'd1;
    localparam logic [1:0] ST_HELD  = 2'd2;
    localparam logic [1:0] ST_REL   = 2'd3;

    if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || REPEAT_DELAY_SCANS < 1 || REPEAT_RATE_SCANS < 1) begin : g_param_err
        $error("keypad_scan: parameter below its minimum");
    end

    logic [3:0]        row_meta_q;
    logic [3:0]        row_sync_q;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [1:0]        col_idx_q, col_idx_d;
    logic [3:0]        col_n_q, col_n_d;
    logic              found_q, found_d;
    logic [3:0]        acc_key_q, acc_key_d;

    logic [1:0]        state_q, state_d;
    logic              cand_vld_q, cand_vld_d;
    logic [3:0]        cand_q, cand_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [3:0]        key_q, key_d;
    logic              valid_q, valid_d;
    logic              press_q, press_d;

    logic              sample;
    logic              sweep_end;
    logic [3:0]        row_hit;
    logic              hit_any;
    logic [1:0]        hit_row;
    logic              found_base;
    logic              res_vld;
    logic [3:0]        res_key;
    logic              res_same_key;
    logic              res_match_cand;
    logic              accept;

    // ---------------------------------------------------------------- column scan
    assign sample    = (slot_q == SLOT_LAST);
    assign sweep_end = sample && (col_idx_q == 2'd3);
    assign row_hit   = ~row_sync_q;

    always_comb begin
        slot_d    = sample ? '0 : slot_q + SLOT_W'(1);
        col_idx_d = sample ? col_idx_q + 2'd1 : col_idx_q;
        col_n_d   = ~(4'b0001 << col_idx_d);
    end

    always_comb begin
        hit_any = |row_hit;
        hit_row = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (row_hit[r]) begin
                hit_row = 2'(r);
            end
        end
    end

    // Column 0 starts a new sweep, so an earlier sweep's hit must not carry over.
    assign found_base = (col_idx_q == 2'd0) ? 1'b0 : found_q;

    always_comb begin
        found_d   = found_q;
        acc_key_d = acc_key_q;
        if (sample) begin
            found_d   = found_base | hit_any;
            acc_key_d = found_base ? acc_key_q : {hit_row, col_idx_q};
        end
    end

    assign res_vld        = found_d;
    assign res_key        = acc_key_d;
    assign res_same_key   = res_vld && (res_key == key_q);
    assign res_match_cand = (res_vld == cand_vld_q) && (!res_vld || (res_key == cand_q));
    assign cnt_inc        = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    // ---------------------------------------------------------------- debounce
    always_comb begin
        state_d    = state_q;
        cand_vld_d = cand_vld_q;
        cand_d     = cand_q;
        cnt_d      = cnt_q;
        key_d      = key_q;
        valid_d    = valid_q;
        accept     = 1'b0;
        if (sweep_end) begin
            case (state_q)
                ST_IDLE: begin
                    if (res_vld) begin
                        state_d    = ST_PRESS;
                        cand_vld_d = 1'b1;
                        cand_d     = res_key;
                        cnt_d      = CNT_ONE;
                    end
                end
                ST_PRESS: begin
                    if (!res_vld) begin
                        state_d    = ST_IDLE;
                        cand_vld_d = 1'b0;
                        cand_d     = 4'd0;
                        cnt_d      = '0;
                    end else if (res_key == cand_q) begin
                        cnt_d = cnt_inc;
                    end else begin
                        cand_d = res_key;
                        cnt_d  = CNT_ONE;
                    end
                end
                ST_HELD: begin
                    if (!res_same_key) begin
                        state_d    = ST_REL;
                        cand_vld_d = res_vld;
                        cand_d     = res_vld ? res_key : 4'd0;
                        cnt_d      = CNT_ONE;
                    end
                end
                default: begin
                    if (res_same_key) begin
                        state_d    = ST_HELD;
                        cand_vld_d = 1'b0;
                        cand_d     = 4'd0;
                        cnt_d      = '0;
                    end else if (res_match_cand) begin
                        cnt_d = cnt_inc;
                    end else begin
                        cand_vld_d = res_vld;
                        cand_d     = res_vld ? res_key : 4'd0;
                        cnt_d      = CNT_ONE;
                    end
                end
            endcase

            // Resolved in the same sweep so DEBOUNCE_SCANS=1 acts on the first sweep.
            if ((state_d == ST_PRESS || state_d == ST_REL) && cnt_d == CNT_MAX) begin
                if (cand_vld_d) begin
                    state_d = ST_HELD;
                    key_d   = cand_d;
                    valid_d = 1'b1;
                    accept  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
                cand_vld_d = 1'b0;
                cand_d     = 4'd0;
                cnt_d      = '0;
            end
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY_SCANS > REPEAT_RATE_SCANS) ? REPEAT_DELAY_SCANS : REPEAT_RATE_SCANS;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d, rpt_inc, rpt_target;
    logic             rpt_first_q, rpt_first_d;
    logic             rpt_fire;

    always_comb begin
        rpt_cnt_d   = rpt_cnt_q;
        rpt_first_d = rpt_first_q;
        rpt_fire    = 1'b0;
        rpt_inc     = rpt_cnt_q + RPT_W'(1);
        rpt_target  = rpt_first_q ? RPT_W'(REPEAT_RATE_SCANS) : RPT_W'(REPEAT_DELAY_SCANS);
        if (sweep_end) begin
            if (state_q == ST_HELD && res_same_key) begin
                if (rpt_inc == rpt_target) begin
                    rpt_fire    = 1'b1;
                    rpt_cnt_d   = '0;
                    rpt_first_d = 1'b1;
                end else begin
                    rpt_cnt_d = rpt_inc;
                end
            end else begin
                rpt_cnt_d   = '0;
                rpt_first_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_cnt_q   <= '0;
            rpt_first_q <= 1'b0;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_first_q <= rpt_first_d;
        end
    end

    assign press_d = accept | rpt_fire;
`else
    assign press_d = accept;
`endif

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
            slot_q     <= '0;
            col_idx_q  <= 2'd0;
            col_n_q    <= 4'b1110;
            found_q    <= 1'b0;
            acc_key_q  <= 4'd0;
            state_q    <= ST_IDLE;
            cand_vld_q <= 1'b0;
            cand_q     <= 4'd0;
            cnt_q      <= '0;
            key_q      <= 4'd0;
            valid_q    <= 1'b0;
            press_q    <= 1'b0;
        end else begin
            row_meta_q <= row_n;
            row_sync_q <= row_meta_q;
            slot_q     <= slot_d;
            col_idx_q  <= col_idx_d;
            col_n_q    <= col_n_d;
            found_q    <= found_d;
            acc_key_q  <= acc_key_d;
            state_q    <= state_d;
            cand_vld_q <= cand_vld_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            key_q      <= key_d;
            valid_q    <= valid_d;
            press_q    <= press_d;
        end
    end

    assign col_n     = col_n_q;
    assign key       = key_q;
    assign key_valid = valid_q;
    assign key_press = press_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_SCANS=2 (16-cycle sweeps) and a behavioural key matrix.
// Key patterns change on sweep boundaries; each vector checks key_valid, key and the key_press pulse count.
module tb_keypad_scan;

    localparam int SWEEP = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  key;
    logic        key_valid;
    logic        key_press;
    logic [15:0] keys;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [15:0] keys;
        int          sweeps;
        logic        exp_valid;
        logic [3:0]  exp_key;
        int          exp_pulses;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    keypad_scan #(
        .SCAN_DIV           (4),
        .DEBOUNCE_SCANS     (2),
        .REPEAT_DELAY_SCANS (4),
        .REPEAT_RATE_SCANS  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_n     (row_n),
        .col_n     (col_n),
        .key       (key),
        .key_valid (key_valid),
        .key_press (key_press)
    );

    // Pressed key at (r,c) pulls row r low while column c is driven low.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic [15:0] k, input int s, input logic v, input logic [3:0] ek, input int p);
        vec_t t;
        t.keys       = k;
        t.sweeps     = s;
        t.exp_valid  = v;
        t.exp_key    = ek;
        t.exp_pulses = p;
        vecs.push_back(t);
    endtask

    task automatic run_sweeps(input int n, output int pulses);
        pulses = 0;
        repeat (n * SWEEP) begin
            @(negedge clk);
            if (key_press) pulses++;
        end
    endtask

    function automatic logic [15:0] kb(input int idx);
        logic [15:0] one = 16'd1;
        return one << idx;
    endfunction

    initial begin
        int          p;
        int          rep_pulses;
        logic [3:0]  one4;
        logic [3:0]  exp_col;

        rst  = 1'b1;
        keys = 16'd0;
        one4 = 4'b0001;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset col_n", col_n, 4'b1110);
        check("reset key", key, 0);
        check("reset key_valid", key_valid, 0);
        check("reset key_press", key_press, 0);
        rst = 1'b0;

        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            exp_col = ~(one4 << ((i / 4) % 4));
            check($sformatf("col_n step %0d", i), col_n, exp_col);
        end
        while (cyc % SWEEP != 0) @(negedge clk);

`ifdef KEYPAD_REPEAT_EN
        rep_pulses = 4;
`else
        rep_pulses = 0;
`endif
        add(16'd0,         2, 1'b0, 4'd0,  0);
        add(kb(6),         1, 1'b0, 4'd0,  0);
        add(kb(6),         1, 1'b1, 4'd6,  1);
        add(kb(6),        10, 1'b1, 4'd6,  rep_pulses);
        add(kb(9),         1, 1'b1, 4'd6,  0);
        add(kb(9),         1, 1'b1, 4'd9,  1);
        add(16'd0,         1, 1'b1, 4'd9,  0);
        add(16'd0,         1, 1'b0, 4'd9,  0);
        for (int i = 0; i < 10; i++) add((i % 2 == 0) ? kb(6) : 16'd0, 1, 1'b0, 4'd9, 0);
        add(kb(3) | kb(9), 2, 1'b1, 4'd9,  1);
        add(16'd0,         2, 1'b0, 4'd9,  0);
        add(kb(6),         2, 1'b1, 4'd6,  1);
        add(16'd0,         1, 1'b1, 4'd6,  0);
        add(kb(6),         1, 1'b1, 4'd6,  0);
        add(16'd0,         2, 1'b0, 4'd6,  0);
        add(kb(13) | kb(10), 2, 1'b1, 4'd13, 1);
        add(16'd0,         2, 1'b0, 4'd13, 0);
        add(kb(14) | kb(6), 2, 1'b1, 4'd6, 1);
        add(16'd0,         2, 1'b0, 4'd6,  0);
        add(kb(5),         1, 1'b0, 4'd6,  0);
        add(kb(7),         1, 1'b0, 4'd6,  0);
        add(kb(7),         1, 1'b1, 4'd7,  1);
        add(16'd0,         2, 1'b0, 4'd7,  0);
        add(kb(15),        2, 1'b1, 4'd15, 1);
        add(kb(0),         2, 1'b1, 4'd0,  1);
        add(16'd0,         2, 1'b0, 4'd0,  0);

        foreach (vecs[i]) begin
            keys = vecs[i].keys;
            run_sweeps(vecs[i].sweeps, p);
            check($sformatf("vec%0d key_valid", i), key_valid, vecs[i].exp_valid);
            check($sformatf("vec%0d key", i), key, vecs[i].exp_key);
            check($sformatf("vec%0d key_press count", i), p, vecs[i].exp_pulses);
        end

        // Reset while a key is held, then re-acceptance with a fresh pulse.
        keys = kb(6);
        run_sweeps(2, p);
        check("pre-reset key_valid", key_valid, 1);
        check("pre-reset pulses", p, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midreset key", key, 0);
        check("midreset key_valid", key_valid, 0);
        check("midreset key_press", key_press, 0);
        check("midreset col_n", col_n, 4'b1110);
        rst = 1'b0;
        run_sweeps(1, p);
        check("post-reset sweep1 key_valid", key_valid, 0);
        check("post-reset sweep1 pulses", p, 0);
        run_sweeps(1, p);
        check("post-reset sweep2 key_valid", key_valid, 1);
        check("post-reset sweep2 key", key, 6);
        check("post-reset sweep2 pulses", p, 1);

        keys = 16'd0;
        run_sweeps(2, p);
        check("final release key_valid", key_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
